// File: rtl/hs_pkg.sv
// Shared types and helpers for the high-score region shuttle.
// Window tables are padded to MAX_REGIONS so one cumulative-length helper serves any REGIONS.
package hs_pkg;

   localparam int unsigned MAX_REGIONS = 8;
   localparam logic [7:0] HS_INDEX_DEF = 8'd4;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StXfer,
      StDrain
   } hs_state_e;

   typedef logic [MAX_REGIONS*16-1:0] len_vec_t;
   typedef logic [MAX_REGIONS:0][31:0] cum_vec_t;

   // cum[k] is the linear offset at which window k begins; cum[MAX_REGIONS] is the total.
   function automatic cum_vec_t cum_len(input len_vec_t reg_len);
      cum_vec_t c;
      c = '0;
      for (int k = 0; k < MAX_REGIONS; k++) begin
         c[k+1] = c[k] + {16'd0, reg_len[k*16 +: 16]};
      end
      return c;
   endfunction

endpackage

// File: rtl/hs_region_map.sv
// Maps a linear ioctl offset onto one of the RAM windows, registered once.
// The register only loads when en is high so it can double as the pending-write address.
module hs_region_map
   import hs_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned REGIONS = 2,
   parameter logic [REGIONS*16-1:0] REG_START = {REGIONS{16'h0}},
   parameter logic [REGIONS*16-1:0] REG_LEN = {REGIONS{16'h0}}
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              en,
   input  logic [24:0]       offset,
   output logic              hit,
   output logic [ADDR_W-1:0] addr
);

   localparam cum_vec_t CUM = cum_len(len_vec_t'(REG_LEN));

   logic [31:0]       off32;
   logic              hit_d;
   logic [ADDR_W-1:0] addr_d;

   assign off32 = {7'd0, offset};

   // Zero-length windows have equal bounds and can never match.
   always_comb begin
      hit_d  = 1'b0;
      addr_d = '0;
      for (int unsigned k = 0; k < REGIONS; k++) begin
         if (!hit_d && off32 >= CUM[k] && off32 < CUM[k+1]) begin
            hit_d  = 1'b1;
            addr_d = ADDR_W'(REG_START[k*16 +: 16]) + ADDR_W'(off32 - CUM[k]);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hit  <= 1'b0;
         addr <= '0;
      end else if (en) begin
         hit  <= hit_d;
         addr <= addr_d;
      end
   end

endmodule

// File: rtl/hs_region_shuttle.sv
// High-score transfer engine between the HPS ioctl stream and game work RAM,
// pausing the CPU around each transfer and mapping offsets across several windows.
module hs_region_shuttle
   import hs_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned REGIONS = 2,
   parameter logic [REGIONS*16-1:0] REG_START = {REGIONS{16'h0}},
   parameter logic [REGIONS*16-1:0] REG_LEN = {REGIONS{16'h0}},
   parameter logic [7:0] HS_INDEX = HS_INDEX_DEF,
   parameter int unsigned SETTLE = 16,
   parameter int unsigned HOLD = 16,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              disable_hs,
   input  logic              ioctl_download,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic [7:0]        ioctl_din,
   output logic [ADDR_W-1:0] ram_address,
   output logic [7:0]        data_to_ram,
   output logic              ram_write,
   input  logic [7:0]        ram_data_in,
   output logic              pause,
   output logic              busy,
   output logic              overrun
);

   hs_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        dir_q, dir_d;

   logic sel;
   logic wr_accept;
   logic issue;
   logic map_en;
   logic map_hit;
   logic [ADDR_W-1:0] map_addr;

   logic [7:0]        buf_data_q;
   logic              buf_valid_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              wr_q;
   logic              overrun_q;
   logic [7:0]        din_q;
   logic              hit_pipe [RAM_LAT];

   // disable_hs only gates the IDLE decision; an active transfer runs to completion.
   assign sel = (ioctl_download | ioctl_upload) & (ioctl_index == HS_INDEX) &
                (~disable_hs | (state_q != StIdle));

   assign wr_accept = ioctl_wr & ioctl_download & sel;
   assign issue     = buf_valid_q & ((state_q == StXfer) | (state_q == StDrain));
   assign map_en    = wr_accept | (ioctl_upload & sel);

   hs_region_map #(
      .ADDR_W   (ADDR_W),
      .REGIONS  (REGIONS),
      .REG_START(REG_START),
      .REG_LEN  (REG_LEN)
   ) u_map (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .en     (map_en),
      .offset (ioctl_addr),
      .hit    (map_hit),
      .addr   (map_addr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      unique case (state_q)
         StIdle: begin
            if (sel) begin
               state_d = StSettle;
               cnt_d   = '0;
               dir_d   = ioctl_upload;
            end
         end
         StSettle: begin
            if (!sel) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else if (cnt_q == 16'(SETTLE - 1)) begin
               state_d = StXfer;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StXfer: begin
            if (!sel) begin
               state_d = StDrain;
               cnt_d   = '0;
            end
         end
         StDrain: begin
            // The hold count only starts once any buffered byte has gone out.
            if (sel) begin
               state_d = StXfer;
               dir_d   = ioctl_upload;
            end else if (!buf_valid_q) begin
               if ({16'd0, cnt_q} + 32'd1 >= 32'(HOLD)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Pending buffer: a new strobe in the issue cycle is fine, the old entry leaves the same edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         buf_data_q  <= '0;
         buf_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         wr_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         if (wr_accept) begin
            buf_data_q  <= ioctl_dout;
            buf_valid_q <= 1'b1;
         end else if (issue) begin
            buf_valid_q <= 1'b0;
         end

         if (wr_accept && buf_valid_q && !issue) begin
            overrun_q <= 1'b1;
         end else if (state_q == StIdle && sel) begin
            overrun_q <= 1'b0;
         end

         // Out-of-range offsets clear the buffer without touching RAM.
         wr_q <= issue & map_hit;
         if (issue && map_hit) begin
            wr_addr_q <= map_addr;
            wr_data_q <= buf_data_q;
         end
      end
   end

   // Hit is delayed to line up with the read data coming back from RAM.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RAM_LAT; i++) hit_pipe[i] <= 1'b0;
         din_q <= '0;
      end else begin
         hit_pipe[0] <= map_hit;
         for (int i = 1; i < RAM_LAT; i++) hit_pipe[i] <= hit_pipe[i-1];
         if (dir_q && state_q == StXfer) begin
            din_q <= hit_pipe[RAM_LAT-1] ? ram_data_in : 8'hFF;
         end
      end
   end

   assign ram_address = (dir_q && state_q == StXfer) ? map_addr : wr_addr_q;
   assign data_to_ram = wr_data_q;
   assign ram_write   = wr_q;
   assign ioctl_din   = din_q;
   assign pause       = (state_q != StIdle);
   assign busy        = (state_q != StIdle);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_hs_region_shuttle.sv
// Directed bench for hs_region_shuttle: vector table for the two-window map plus
// hand sequences for settle, overrun, release, reselect, gating and reset abort.
module tb_hs_region_shuttle;

   localparam int unsigned SETTLE  = 4;
   localparam int unsigned HOLD    = 16;
   localparam int unsigned RAM_LAT = 1;

   logic        clk_sys;
   logic        reset_n;
   logic        disable_hs;
   logic        ioctl_download;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wr;
   logic [7:0]  ioctl_din;
   logic [15:0] ram_address;
   logic [7:0]  data_to_ram;
   logic        ram_write;
   logic [7:0]  ram_data_in;
   logic        pause;
   logic        busy;
   logic        overrun;

   hs_region_shuttle #(
      .ADDR_W   (16),
      .REGIONS  (2),
      .REG_START({16'hC010, 16'h8000}),
      .REG_LEN  ({16'd2, 16'd4}),
      .HS_INDEX (8'd4),
      .SETTLE   (SETTLE),
      .HOLD     (HOLD),
      .RAM_LAT  (RAM_LAT)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .disable_hs    (disable_hs),
      .ioctl_download(ioctl_download),
      .ioctl_upload  (ioctl_upload),
      .ioctl_index   (ioctl_index),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .ioctl_wr      (ioctl_wr),
      .ioctl_din     (ioctl_din),
      .ram_address   (ram_address),
      .data_to_ram   (data_to_ram),
      .ram_write     (ram_write),
      .ram_data_in   (ram_data_in),
      .pause         (pause),
      .busy          (busy),
      .overrun       (overrun)
   );

   typedef struct {
      logic        up;
      logic [24:0] off;
      logic [7:0]  data;
      logic [15:0] exp_addr;
      logic [7:0]  exp_val;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_rec_t;

   vec_t    vecs [13];
   wr_rec_t wlog [$];
   int      cyc;
   int      checks;
   int      errors;

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   function automatic logic [7:0] ram_model(input logic [15:0] a);
      case (a)
         16'h8000: return 8'hA0;
         16'h8001: return 8'hA1;
         16'h8002: return 8'hA2;
         16'h8003: return 8'hA3;
         16'hC010: return 8'hA4;
         16'hC011: return 8'hA5;
         default:  return 8'h00;
      endcase
   endfunction

   // One-cycle-latency game RAM.
   always @(posedge clk_sys) ram_data_in <= ram_model(ram_address);

   always @(negedge clk_sys) begin
      if (ram_write) wlog.push_back('{ram_address, data_to_ram, cyc});
   end

   function automatic wr_rec_t get_rec(input int idx);
      wr_rec_t r;
      r = '{16'hxxxx, 8'hxx, -1};
      if (idx >= 0 && idx < wlog.size()) r = wlog[idx];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100 && busy; i++) tick();
      check(name, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int      t_sel, f, s, w, base, idx;
      int      wcyc [6];
      logic    held, seen;
      wr_rec_t r;

      checks = 0;
      errors = 0;

      vecs[0]  = '{1'b0, 25'd0, 8'h10, 16'h8000, 8'h10};
      vecs[1]  = '{1'b0, 25'd1, 8'h11, 16'h8001, 8'h11};
      vecs[2]  = '{1'b0, 25'd2, 8'h12, 16'h8002, 8'h12};
      vecs[3]  = '{1'b0, 25'd3, 8'h13, 16'h8003, 8'h13};
      vecs[4]  = '{1'b0, 25'd4, 8'h14, 16'hC010, 8'h14};
      vecs[5]  = '{1'b0, 25'd5, 8'h15, 16'hC011, 8'h15};
      vecs[6]  = '{1'b1, 25'd0, 8'h00, 16'h0000, 8'hA0};
      vecs[7]  = '{1'b1, 25'd1, 8'h00, 16'h0000, 8'hA1};
      vecs[8]  = '{1'b1, 25'd2, 8'h00, 16'h0000, 8'hA2};
      vecs[9]  = '{1'b1, 25'd3, 8'h00, 16'h0000, 8'hA3};
      vecs[10] = '{1'b1, 25'd4, 8'h00, 16'h0000, 8'hA4};
      vecs[11] = '{1'b1, 25'd5, 8'h00, 16'h0000, 8'hA5};
      vecs[12] = '{1'b1, 25'd6, 8'h00, 16'h0000, 8'hFF};

      reset_n        = 1'b0;
      disable_hs     = 1'b0;
      ioctl_download = 1'b0;
      ioctl_upload   = 1'b0;
      ioctl_index    = 8'd4;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_wr       = 1'b0;

      repeat (3) tick();
      check("rst_ioctl_din", {24'd0, ioctl_din}, 32'h0);
      check("rst_ram_address", {16'd0, ram_address}, 32'h0);
      check("rst_data_to_ram", {24'd0, data_to_ram}, 32'h0);
      check("rst_ram_write", {31'd0, ram_write}, 32'h0);
      check("rst_pause", {31'd0, pause}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      check("rst_overrun", {31'd0, overrun}, 32'h0);
      reset_n = 1'b1;
      repeat (2) tick();

      // Download: first byte arrives with the select, the rest once in XFER.
      base           = wlog.size();
      ioctl_download = 1'b1;
      ioctl_addr     = vecs[0].off;
      ioctl_dout     = vecs[0].data;
      ioctl_wr       = 1'b1;
      t_sel          = cyc;
      wcyc[0]        = cyc;
      tick();
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      check("sel_pause", {31'd0, pause}, 32'd1);
      check("sel_busy", {31'd0, busy}, 32'd1);
      repeat (SETTLE + 2) tick();
      for (int i = 1; i < 6; i++) begin
         ioctl_addr = vecs[i].off;
         ioctl_dout = vecs[i].data;
         ioctl_wr   = 1'b1;
         wcyc[i]    = cyc;
         tick();
         ioctl_wr = 1'b0;
         repeat (3) tick();
      end
      repeat (4) tick();
      check("dl_count", 32'(wlog.size() - base), 32'd6);
      for (int i = 0; i < 6; i++) begin
         r = get_rec(base + i);
         check($sformatf("dl_addr_%0d", i), {16'd0, r.addr}, {16'd0, vecs[i].exp_addr});
         check($sformatf("dl_data_%0d", i), {24'd0, r.data}, {24'd0, vecs[i].exp_val});
      end
      r = get_rec(base);
      check("dl_first_not_before_settle", {31'd0, (r.cyc - t_sel) >= 5}, 32'd1);
      r = get_rec(base + 1);
      check("dl_write_latency", 32'(r.cyc - wcyc[1]), 32'd2);

      // Release: pause drops exactly HOLD+1 cycles after the deselect.
      ioctl_download = 1'b0;
      f = cyc;
      repeat (HOLD) @(posedge clk_sys);
      @(negedge clk_sys);
      check("release_pause_hi", {31'd0, pause}, 32'd1);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("release_pause_lo", {31'd0, pause}, 32'd0);
      check("release_cycle", 32'(cyc - f), 32'(HOLD + 1));
      tick();

      // Upload: each address held 9 cycles, data checked exactly RAM_LAT+2 later.
      ioctl_addr   = 25'd6;
      ioctl_upload = 1'b1;
      repeat (SETTLE + 3) tick();
      for (int i = 6; i < 13; i++) begin
         ioctl_addr = vecs[i].off;
         repeat (RAM_LAT + 2) @(posedge clk_sys);
         @(negedge clk_sys);
         check($sformatf("ul_din_off%0d", vecs[i].off), {24'd0, ioctl_din},
               {24'd0, vecs[i].exp_val});
         tick();
         repeat (5) tick();
      end
      ioctl_upload = 1'b0;
      wait_idle("ul_idle");

      // Overrun: two strobes back to back during SETTLE, only the second lands.
      tick();
      ioctl_download = 1'b1;
      ioctl_addr     = 25'd0;
      s              = cyc;
      tick();
      ioctl_addr = 25'd0;
      ioctl_dout = 8'h11;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_addr = 25'd1;
      ioctl_dout = 8'h22;
      tick();
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      base = wlog.size();
      repeat (SETTLE + 4) tick();
      check("ovr_count", 32'(wlog.size() - base), 32'd1);
      r = get_rec(base);
      check("ovr_addr", {16'd0, r.addr}, 32'h8001);
      check("ovr_data", {24'd0, r.data}, 32'h22);
      check("ovr_issue_after_settle", {31'd0, (r.cyc - s) >= 5}, 32'd1);

      // Reselect during DRAIN: straight back to XFER, pause never drops.
      ioctl_download = 1'b0;
      f    = cyc;
      held = 1'b1;
      repeat (3) begin
         tick();
         if (!pause) held = 1'b0;
      end
      ioctl_download = 1'b1;
      tick();
      if (!pause) held = 1'b0;
      ioctl_addr = 25'd4;
      ioctl_dout = 8'h77;
      ioctl_wr   = 1'b1;
      w          = cyc;
      base       = wlog.size();
      tick();
      ioctl_wr = 1'b0;
      if (!pause) held = 1'b0;
      repeat (3) begin
         tick();
         if (!pause) held = 1'b0;
      end
      check("reselect_pause_held", {31'd0, held}, 32'd1);
      r = get_rec(base);
      check("reselect_addr", {16'd0, r.addr}, 32'hC010);
      check("reselect_data", {24'd0, r.data}, 32'h77);
      check("reselect_latency", 32'(r.cyc - w), 32'd2);
      ioctl_download = 1'b0;
      wait_idle("reselect_idle");

      // Gating: disable_hs, then a foreign index; neither may pause or write.
      for (int pass = 0; pass < 2; pass++) begin
         tick();
         disable_hs     = (pass == 0);
         ioctl_index    = (pass == 0) ? 8'd4 : 8'd5;
         ioctl_download = 1'b1;
         base           = wlog.size();
         seen           = 1'b0;
         for (int j = 0; j < 20; j++) begin
            ioctl_wr   = (j % 4 == 0);
            ioctl_addr = 25'(j % 6);
            ioctl_dout = 8'(8'h40 + j);
            tick();
            if (pause) seen = 1'b1;
         end
         ioctl_wr       = 1'b0;
         ioctl_download = 1'b0;
         repeat (3) tick();
         if (pause) seen = 1'b1;
         check($sformatf("gate%0d_pause", pass), {31'd0, seen}, 32'd0);
         check($sformatf("gate%0d_writes", pass), 32'(wlog.size() - base), 32'd0);
      end
      disable_hs  = 1'b0;
      ioctl_index = 8'd4;

      // Reset abort: buffer holds a byte when reset_n drops mid-XFER.
      tick();
      ioctl_download = 1'b1;
      ioctl_addr     = 25'd2;
      tick();
      @(negedge clk_sys);
      check("new_xfer_clears_overrun", {31'd0, overrun}, 32'd0);
      repeat (SETTLE + 2) tick();
      ioctl_dout = 8'h99;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      base     = wlog.size();
      reset_n  = 1'b0;
      #1;
      check("abort_pause", {31'd0, pause}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ram_write", {31'd0, ram_write}, 32'd0);
      check("abort_ram_address", {16'd0, ram_address}, 32'd0);
      check("abort_data_to_ram", {24'd0, data_to_ram}, 32'd0);
      ioctl_download = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (10) tick();
      check("abort_no_write", 32'(wlog.size() - base), 32'd0);
      idx = wlog.size();
      check("abort_still_idle", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
